// File: rtl/fft_output_buffer.sv
// Frame buffer between the FFT core and the bus master: captures one frame of
// 2^ADDR_W samples, optionally bit-reversing the write index, then serves reads.
module fft_output_buffer #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 9,
    parameter bit BITREV = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              fft_done,
    input  logic [ADDR_W-1:0] sampled_address,
    input  logic              sReEn,
    output logic [DATA_W-1:0] sampled_data,
    input  logic              release_drain,
    output logic              frame_err,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, FILL, DONE, HOLD} state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = '1;

    state_t            state;
    state_t            next_state;
    logic [ADDR_W-1:0] wr_cnt;
    logic [ADDR_W-1:0] wr_cnt_next;
    logic [ADDR_W-1:0] wr_addr;
    logic              wr_en;
    logic              restart;
    logic              take;

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    function automatic logic [ADDR_W-1:0] map_addr(input logic [ADDR_W-1:0] idx);
        logic [ADDR_W-1:0] r;
        r = idx;
        if (BITREV) begin
            for (int i = 0; i < ADDR_W; i++) begin
                r[i] = idx[ADDR_W-1-i];
            end
        end
        return r;
    endfunction

    assign take = in_valid & in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (take && frame_start) begin
                    next_state = FILL;
                end
            end
            FILL: begin
                if (take && !frame_start && wr_cnt == LAST_IDX) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                next_state = release_drain ? IDLE : HOLD;
            end
            HOLD: begin
                if (release_drain || (sReEn && sampled_address == LAST_IDX)) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // A frame_start transfer always lands at index 0, whether it opens or restarts a frame.
    always_comb begin
        wr_en       = 1'b0;
        wr_addr     = map_addr(wr_cnt);
        wr_cnt_next = wr_cnt;
        restart     = 1'b0;
        if (take) begin
            if (state == IDLE && frame_start) begin
                wr_en       = 1'b1;
                wr_addr     = '0;
                wr_cnt_next = ADDR_W'(1);
            end else if (state == FILL) begin
                wr_en = 1'b1;
                if (frame_start) begin
                    wr_addr     = '0;
                    wr_cnt_next = ADDR_W'(1);
                    restart     = 1'b1;
                end else begin
                    wr_cnt_next = wr_cnt + ADDR_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_cnt    <= '0;
            in_ready  <= 1'b1;
            fft_done  <= 1'b0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
        end else begin
            wr_cnt    <= wr_cnt_next;
            in_ready  <= (next_state == IDLE) || (next_state == FILL);
            fft_done  <= (next_state == DONE);
            frame_err <= restart;
            busy      <= (next_state != IDLE);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sampled_data <= '0;
        end else if (state == HOLD && sReEn) begin
            sampled_data <= mem[sampled_address];
        end
    end

endmodule

// File: doc/fft_output_buffer.md
Name: fft_output_buffer

Overview:
- Frame buffer between the FFT core and avalonMaster.
- Captures one complete FFT output frame of 2^ADDR_W samples from the core's streaming output.
- Stores samples at bit-reversed addresses (when BITREV=1) so readout is in natural order.
- Pulses fft_done when the frame is complete, then serves random-access reads (sampled_address/sReEn -> sampled_data) until the drain finishes or is aborted.

Parameters:
DATA_W, 16, sample width
ADDR_W, 9, log2 of frame length (512 samples)
BITREV, 1, 1 = write address is bit-reversed input index; 0 = linear

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
frame_start  in  1  marks the first sample of a frame; qualified by in_valid
in_valid  in  1  sample valid from FFT core
in_data  in  DATA_W  sample from FFT core
in_ready  out  1  buffer accepts samples; a transfer occurs when in_valid & in_ready
fft_done  out  1  one-cycle pulse: frame stored and readable
sampled_address  in  ADDR_W  natural-order read index from master
sReEn  in  1  read enable from master
sampled_data  out  DATA_W  read data, registered
release  in  1  abort drain (master error path); return to IDLE
frame_err  out  1  one-cycle pulse on a truncated/restarted frame
busy  out  1  high in FILL, DONE and HOLD

Behaviour:
- Reset: clk and rst only; synchronous, active-high. All state is cleared on the first rising edge with rst=1: state=IDLE, wr_cnt=0, in_ready=1, fft_done=0, frame_err=0, busy=0, sampled_data=0. RAM contents are not reset.
- Storage: 2^ADDR_W x DATA_W single-write/single-read RAM, inferable as block RAM.
- Write address = BITREV ? bitreverse(wr_cnt) : wr_cnt, where wr_cnt is an ADDR_W-bit counter.
- FSM states: IDLE, FILL, DONE, HOLD.
- IDLE:
  - in_ready=1.
  - A transfer with frame_start=1 writes the sample at index 0, sets wr_cnt=1 and moves to FILL.
  - A transfer with frame_start=0 is discarded; stay in IDLE.
- FILL:
  - in_ready=1. Each transfer writes at address(wr_cnt) and increments wr_cnt.
  - A transfer at wr_cnt = 2^ADDR_W-1 writes the last sample, wraps wr_cnt to 0 and moves to DONE.
  - A transfer with frame_start=1 in FILL restarts the frame: write at index 0, wr_cnt=1, pulse frame_err for one cycle, stay in FILL.
- DONE:
  - One cycle. fft_done=1, in_ready=0. Next state is HOLD.
- HOLD:
  - in_ready=0; in_valid is ignored.
  - Read: sReEn=1 latches RAM[sampled_address] into sampled_data on the next edge (latency 1). sampled_data holds its value while sReEn=0.
  - The master holds its address for at least 3 cycles, so latency 1 is sufficient.
  - Exit on sReEn=1 with sampled_address = 2^ADDR_W-1: the read completes (sampled_data updates), then the FSM enters IDLE.
  - Exit on release=1: go to IDLE on the next edge. Any read issued that cycle still completes.
- Outside HOLD, sReEn is ignored and sampled_data holds its value.
- release is ignored in IDLE and FILL. In DONE it takes effect (next state IDLE); fft_done still pulses that cycle.
- Priority: rst > release > normal transitions.
- Throughput: one sample per cycle in FILL, so minimum fill time is 2^ADDR_W cycles from the frame_start transfer to the fft_done cycle.
- fft_done asserts on the cycle after the last write edge.
- fft_done, frame_err and in_ready are registered outputs with no combinational input-to-output paths.

Test Plan:
- Reset:
  - Drive rst=1 for 2 cycles mid-FILL (wr_cnt=100), then continue streaming -> in_ready=1, busy=0, fft_done stays 0.
  - A new frame_start is required to begin capture.
- Full frame, BITREV=1:
  - Stream in_data=index 0..511 back-to-back, frame_start on index 0 -> fft_done pulses once, exactly 1 cycle, on the cycle after the 512th transfer.
  - Reading addresses 0..511 returns bitreverse9(addr), e.g. addr 1 -> 256, addr 3 -> 384.
- Backpressure and drain:
  - In HOLD, drive in_valid=1 with data 0xAAAA -> in_ready=0 and the buffer is unchanged.
  - Read address 511 -> sampled_data valid after 1 cycle; state IDLE, in_ready=1 on the following cycle.
- Restart:
  - frame_start reasserted at wr_cnt=300 -> frame_err pulses once.
  - A subsequent 512-sample frame completes normally; reads return only new-frame data.
- Abort:
  - In HOLD after reading addresses 0..9, assert release for 1 cycle -> IDLE next cycle.
  - A new frame is accepted and a second fft_done pulse occurs.
- Gapped input:
  - in_valid toggling 1/0 during FILL -> only qualified samples are counted.
  - fft_done arrives after the 512th valid transfer; BITREV=0 readout is linear.
